// File: rtl/aes128_decrypt_core.sv
// rtl/aes128_decrypt_core.sv - iterative AES-128 inverse cipher, one round per clock
// Optional KEY_CACHE_EN: skip key expansion when in_key matches the last expanded key.
module aes128_decrypt_core #(
  parameter logic ZERO_ON_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_pt,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;

  // Byte x of each table sits at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    logic [7:0] r;
    case (k)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte (col c, row r) lives at index 4c+r; row r rotates right by r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  state_t        r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [127:0]  r_out_pt;
  logic          r_busy;
  logic [3:0]    r_rnd;
  logic [3:0]    r_kcnt;
  logic [127:0]  r_s;
  logic [31:0]   r_w [0:43];

  logic [5:0]    w_kbase;
  logic [5:0]    w_kprev;
  logic [5:0]    w_rbase;
  logic [31:0]   w_p3;
  logic [31:0]   w_t;
  logic [31:0]   w_n0;
  logic [31:0]   w_n1;
  logic [31:0]   w_n2;
  logic [31:0]   w_n3;
  logic [127:0]  w_rk;
  logic [127:0]  w_rk0;
  logic [127:0]  w_rk10;
  logic [127:0]  w_round;
  logic [127:0]  w_final;
  logic          w_hit;

  // Key expansion step k writes W[4k..4k+3] from W[4k-4..4k-1].
  assign w_kbase = {r_kcnt, 2'b00};
  assign w_kprev = w_kbase - 6'd4;
  assign w_p3    = r_w[w_kprev + 6'd3];
  assign w_t     = {sbox(w_p3[23:16]), sbox(w_p3[15:8]), sbox(w_p3[7:0]), sbox(w_p3[31:24])}
                   ^ {rcon(r_kcnt), 24'h0};
  assign w_n0    = r_w[w_kprev] ^ w_t;
  assign w_n1    = r_w[w_kprev + 6'd1] ^ w_n0;
  assign w_n2    = r_w[w_kprev + 6'd2] ^ w_n1;
  assign w_n3    = w_p3 ^ w_n2;

  assign w_rbase = {r_rnd, 2'b00};
  assign w_rk    = {r_w[w_rbase], r_w[w_rbase + 6'd1], r_w[w_rbase + 6'd2], r_w[w_rbase + 6'd3]};
  assign w_rk0   = {r_w[0], r_w[1], r_w[2], r_w[3]};
  assign w_rk10  = {r_w[40], r_w[41], r_w[42], r_w[43]};
  assign w_round = inv_mix(inv_shift_sub(r_s) ^ w_rk);
  assign w_final = inv_shift_sub(r_s) ^ w_rk0;

`ifdef KEY_CACHE_EN
  logic r_cache_vld;

  // W0..W3 double as the cached key; the expansion is trusted only once it completes.
  assign w_hit = r_cache_vld && (in_key == w_rk0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_vld <= 1'b0;
    end else if (r_state == S_IDLE && in_valid && !w_hit) begin
      r_cache_vld <= 1'b0;
    end else if (r_state == S_KEXP && r_kcnt == 4'd10) begin
      r_cache_vld <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_pt    <= '0;
      r_busy      <= 1'b0;
      r_rnd       <= 4'd0;
      r_kcnt      <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_s        <= in_ct;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_hit) begin
              r_state <= S_INIT;
            end else begin
              r_w[0]  <= in_key[127:96];
              r_w[1]  <= in_key[95:64];
              r_w[2]  <= in_key[63:32];
              r_w[3]  <= in_key[31:0];
              r_kcnt  <= 4'd1;
              r_state <= S_KEXP;
            end
          end
        end
        S_KEXP: begin
          r_w[w_kbase]        <= w_n0;
          r_w[w_kbase + 6'd1] <= w_n1;
          r_w[w_kbase + 6'd2] <= w_n2;
          r_w[w_kbase + 6'd3] <= w_n3;
          r_kcnt              <= r_kcnt + 4'd1;
          if (r_kcnt == 4'd10) r_state <= S_INIT;
        end
        S_INIT: begin
          r_s     <= r_s ^ w_rk10;
          r_rnd   <= 4'd9;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_s   <= w_round;
          r_rnd <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_out_pt    <= w_final;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (ZERO_ON_IDLE) r_out_pt <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pt    = r_out_pt;
  assign busy      = r_busy;

endmodule
